row_hamming_enc_pipe: RTL and testbench

- Pipelined row-address encoder for the FE-I4 emulator hit path.
- Converts an 8-bit binary pixel row into the 12-bit Hamming-protected Gray word consumed by the downstream row decoder.
- Runs with a valid/ready handshake on both sides, so the hit generator can stream one row per clock.
- Optionally injects single-bit errors to exercise the decoder's correction path.

---
 rtl/row_hamming_enc_pipe_if.sv | 22 ++
 rtl/row_hamming_enc_pipe.sv | 116 +++++++++++
 tb/tb_row_hamming_enc_pipe.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/row_hamming_enc_pipe_if.sv
// Purpose: valid/ready handshake bundle for the row Hamming encoder.
//   in_valid/in_ready/in_row    : binary row stream into the encoder
//   out_valid/out_ready/out_word: encoded 12-bit row word to the decoder
// master: hit generator + downstream consumer side; slave: the encoder.
interface row_hamming_enc_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_row;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_word;

  modport master (
    output in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_word
  );

  modport slave (
    input  in_valid, in_row, out_ready,
    output in_ready, out_valid, out_word
  );
endinterface

// File: rtl/row_hamming_enc_pipe.sv
// Purpose: two-stage pipelined encoder turning an 8-bit binary pixel row into
// a 12-bit Hamming-protected Gray word for the FE-I4 emulator row decoder.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : in_valid/in_ready/in_row, out_valid/out_ready/out_word
//   word_cnt     : saturating count of words delivered on the output
//   err_pos      : bit index to flip, 0..11        (ROW_ERR_INJ_EN only)
//   err_period   : inject on every Nth word, 0=off (ROW_ERR_INJ_EN only)
//   err_flag     : current out_word carries an injected error (ROW_ERR_INJ_EN only)
// Optional feature macro: ROW_ERR_INJ_EN (single-bit error injection).
module row_hamming_enc_pipe #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  row_hamming_enc_pipe_if.slave bus,
  output logic [CNT_W-1:0]     word_cnt
`ifdef ROW_ERR_INJ_EN
  ,
  input  logic [3:0]           err_pos,
  input  logic [7:0]           err_period,
  output logic                 err_flag
`endif
);

  localparam int unsigned ROW_W  = 8;
  localparam int unsigned WORD_W = 12;

  logic              r_s1_v;
  logic [WORD_W-1:0] r_s1_word;
  logic              r_s2_v;
  logic [WORD_W-1:0] r_out_word;
  logic [CNT_W-1:0]  r_word_cnt;

  logic              w_s1_adv;
  logic              w_s2_adv;
  logic [ROW_W-1:0]  w_gray;
  logic [WORD_W-1:0] w_enc;
  logic [WORD_W-1:0] w_mask;

  // Handshake: a stage may load when it is empty or its content moves on.
  assign w_s2_adv     = !r_s2_v || bus.out_ready;
  assign w_s1_adv     = !r_s1_v || w_s2_adv;
  assign bus.in_ready = w_s1_adv;
  assign bus.out_valid = r_s2_v;
  assign bus.out_word  = r_out_word;
  assign word_cnt      = r_word_cnt;

  // Gray conversion, bit placement and parity generation.
  always_comb begin
    w_gray    = bus.in_row ^ (bus.in_row >> 1);
    w_enc     = '0;
    w_enc[2]  = w_gray[0];
    w_enc[4]  = w_gray[1];
    w_enc[5]  = w_gray[2];
    w_enc[11] = w_gray[3];
    w_enc[8]  = w_gray[4];
    w_enc[9]  = w_gray[5];
    w_enc[10] = w_gray[6];
    w_enc[6]  = w_gray[7];
    w_enc[0]  = w_enc[2] ^ w_enc[4] ^ w_enc[6] ^ w_enc[8] ^ w_enc[10];
    w_enc[1]  = w_enc[2] ^ w_enc[5] ^ w_enc[6] ^ w_enc[9] ^ w_enc[10];
    w_enc[3]  = w_enc[4] ^ w_enc[5] ^ w_enc[6] ^ w_enc[11];
    w_enc[7]  = w_enc[8] ^ w_enc[9] ^ w_enc[10] ^ w_enc[11];
  end

`ifdef ROW_ERR_INJ_EN
  logic [7:0] r_inj_cnt;
  logic       r_err_flag;
  logic [8:0] w_inj_next;
  logic       w_inj;

  // The counter tracks words passed to the output since the last injection;
  // >= keeps a period lowered below the current count from being skipped.
  assign w_inj_next = {1'b0, r_inj_cnt} + 9'd1;
  assign w_inj      = (err_period != 8'd0) && (w_inj_next >= {1'b0, err_period});
  // Positions 12..15 shift out of the word: flag pulses, no bit flips.
  assign w_mask     = w_inj ? (WORD_W'(1) << err_pos) : '0;
  assign err_flag   = r_err_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inj_cnt  <= '0;
      r_err_flag <= 1'b0;
    end else if (w_s2_adv && r_s1_v) begin
      r_err_flag <= w_inj;
      r_inj_cnt  <= w_inj ? 8'd0 : w_inj_next[7:0];
    end
  end
`else
  assign w_mask = '0;
`endif

  // Pipeline stages and delivered-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v     <= 1'b0;
      r_s1_word  <= '0;
      r_s2_v     <= 1'b0;
      r_out_word <= '0;
      r_word_cnt <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_v <= bus.in_valid;
        if (bus.in_valid) r_s1_word <= w_enc;
      end
      if (w_s2_adv) begin
        r_s2_v <= r_s1_v;
        if (r_s1_v) r_out_word <= r_s1_word ^ w_mask;
      end
      if (r_s2_v && bus.out_ready && (r_word_cnt != '1))
        r_word_cnt <= r_word_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_row_hamming_enc_pipe.sv
// Directed self-checking bench for row_hamming_enc_pipe. A second instance
// with a 4-bit counter sees the same traffic to exercise saturation.
module tb_row_hamming_enc_pipe;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [15:0] word_cnt;
  logic [3:0]  word_cnt_sat;

  row_hamming_enc_pipe_if bus ();
  row_hamming_enc_pipe_if bus_sat ();

  assign bus_sat.in_valid  = bus.in_valid;
  assign bus_sat.in_row    = bus.in_row;
  assign bus_sat.out_ready = bus.out_ready;

`ifdef ROW_ERR_INJ_EN
  logic [3:0] err_pos;
  logic [7:0] err_period;
  logic       err_flag;
  logic       err_flag_sat;
`endif

  row_hamming_enc_pipe #(.CNT_W(16)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .word_cnt  (word_cnt)
`ifdef ROW_ERR_INJ_EN
    ,
    .err_pos   (err_pos),
    .err_period(err_period),
    .err_flag  (err_flag)
`endif
  );

  row_hamming_enc_pipe #(.CNT_W(4)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_sat),
    .word_cnt  (word_cnt_sat)
`ifdef ROW_ERR_INJ_EN
    ,
    .err_pos   (err_pos),
    .err_period(err_period),
    .err_flag  (err_flag_sat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return at the falling edge where outputs are stable.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [3:0] syndrome(input logic [11:0] w);
    syndrome[0] = w[0] ^ w[2] ^ w[4] ^ w[6] ^ w[8] ^ w[10];
    syndrome[1] = w[1] ^ w[2] ^ w[5] ^ w[6] ^ w[9] ^ w[10];
    syndrome[2] = w[3] ^ w[4] ^ w[5] ^ w[6] ^ w[11];
    syndrome[3] = w[7] ^ w[8] ^ w[9] ^ w[10] ^ w[11];
  endfunction

  function automatic logic [7:0] decode_row(input logic [11:0] w);
    logic [7:0] g;
    logic [7:0] b;
    g = {w[6], w[10], w[9], w[8], w[11], w[5], w[4], w[2]};
    b[7] = g[7];
    for (int k = 6; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction

  initial begin
    logic [7:0]  rows [4];
    logic [11:0] exp4 [4];
    logic [11:0] w;

    rows = '{8'd0, 8'd1, 8'd2, 8'd255};
    exp4 = '{12'h000, 12'h007, 12'h01E, 12'h04B};
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_row    = 8'd0;
    bus.out_ready = 1'b0;
`ifdef ROW_ERR_INJ_EN
    err_pos    = 4'd0;
    err_period = 8'd0;
`endif

    // Reset state
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_word", 32'(bus.out_word), 32'h000);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Rows 0,1,2,255 streamed with out_ready high
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_row = rows[i];
      tick();
      if (i == 0) check("lat_out_valid0", 32'(bus.out_valid), 32'd0);
      else begin
        check("stream_valid", 32'(bus.out_valid), 32'd1);
        check("stream_word", 32'(bus.out_word), 32'(exp4[i-1]));
      end
    end
    bus.in_valid = 1'b0;
    tick();
    check("stream_word_last", 32'(bus.out_word), 32'(exp4[3]));
    tick();
    check("stream_drained", 32'(bus.out_valid), 32'd0);
    check("stream_cnt", 32'(word_cnt), 32'd4);

    // Exhaustive 0..255: zero syndrome and Gray decode back to the row
    bus.in_valid = 1'b1;
    for (int i = 0; i < 257; i++) begin
      if (i < 256) bus.in_row = 8'(i);
      else bus.in_valid = 1'b0;
      tick();
      if (i >= 1) begin
        w = bus.out_word;
        check("exh_valid", 32'(bus.out_valid), 32'd1);
        check("exh_syndrome", 32'(syndrome(w)), 32'd0);
        check("exh_decode", 32'(decode_row(w)), 32'(i - 1));
      end
    end
    tick();
    check("exh_drained", 32'(bus.out_valid), 32'd0);
    check("exh_cnt", 32'(word_cnt), 32'd260);

    // Back-pressure: out_ready low, two words buffer, then release
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_row    = 8'd10;
    #1 check("bp_in_ready0", 32'(bus.in_ready), 32'd1);
    tick();
    check("bp_valid0", 32'(bus.out_valid), 32'd0);
    bus.in_row = 8'd11;
    #1 check("bp_in_ready1", 32'(bus.in_ready), 32'd1);
    tick();
    check("bp_valid1", 32'(bus.out_valid), 32'd1);
    check("bp_word10", 32'(bus.out_word), 32'h8BC);
    bus.in_row = 8'd12;
    for (int k = 0; k < 5; k++) begin
      #1 check("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_word", 32'(bus.out_word), 32'h8BC);
    end
    check("bp_hold_cnt", 32'(word_cnt), 32'd260);
    bus.out_ready = 1'b1;
    #1 check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("bp_word11", 32'(bus.out_word), 32'h8BB);
    bus.in_row = 8'd13;
    tick();
    check("bp_word12", 32'(bus.out_word), 32'h891);
    bus.in_valid = 1'b0;
    tick();
    check("bp_word13", 32'(bus.out_word), 32'h896);
    tick();
    check("bp_drained", 32'(bus.out_valid), 32'd0);
    check("bp_cnt", 32'(word_cnt), 32'd264);
    check("sat_cnt", 32'(word_cnt_sat), 32'd15);

    // Reset with both stages full drops everything
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_row    = 8'd20;
    tick();
    bus.in_row = 8'd21;
    tick();
    check("rf_full_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rf_out_valid", 32'(bus.out_valid), 32'd0);
    check("rf_out_word", 32'(bus.out_word), 32'h000);
    check("rf_in_ready", 32'(bus.in_ready), 32'd1);
    check("rf_cnt", 32'(word_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_row    = 8'd7;
    tick();
    check("rf_lat_valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;
    tick();
    check("rf_row7_valid", 32'(bus.out_valid), 32'd1);
    check("rf_row7_word", 32'(bus.out_word), 32'h02A);
    tick();
    check("rf_row7_only", 32'(bus.out_valid), 32'd0);
    check("rf_row7_cnt", 32'(word_cnt), 32'd1);

`ifdef ROW_ERR_INJ_EN
    // Injection: every 3rd word of row 0 has bit 5 flipped
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    err_period = 8'd3;
    err_pos    = 4'd5;
    bus.in_valid = 1'b1;
    bus.in_row   = 8'd0;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) bus.in_valid = 1'b0;
      tick();
      if (i >= 1) begin
        check("inj_word", 32'(bus.out_word), (i % 3 == 0) ? 32'h020 : 32'h000);
        check("inj_flag", 32'(err_flag), (i % 3 == 0) ? 32'd1 : 32'd0);
      end
    end
    tick();
    check("inj_drained", 32'(bus.out_valid), 32'd0);
    // Out-of-range position: flag pulses, word stays clean
    err_period = 8'd1;
    err_pos    = 4'd13;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("inj_oor_word", 32'(bus.out_word), 32'h000);
    check("inj_oor_flag", 32'(err_flag), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
